// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state, funct3 and error-code definitions for the load/store unit
package lsu_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ACCESS   = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;
endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable, store-data replication and load extraction
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rd_data,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wr_data,
    output logic [XLEN-1:0]   load_data
);
    logic [XLEN-1:0] shifted;

    // funct3[1:0] is the access width for loads and stores alike; funct3[2] selects zero-extension.
    always_comb begin
        shifted   = rd_data >> {offset, 3'b000};
        be        = 4'b1111;
        wr_data   = wdata;
        load_data = shifted;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << offset;
                wr_data   = {4{wdata[7:0]}};
                load_data = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                be        = 4'b0011 << offset;
                wr_data   = {2{wdata[15:0]}};
                load_data = funct3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be        = 4'b1111;
                wr_data   = wdata;
                load_data = shifted;
            end
        endcase
    end
endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: accept, fault check, bus handshake and writeback
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_LEN = 14
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic                ex_load,
    input  logic                ex_store,
    input  logic [2:0]          ex_funct3,
    input  logic [XLEN-1:0]     ex_addr,
    input  logic [XLEN-1:0]     ex_wdata,
    input  logic [4:0]          ex_rd,
    output logic [ADDR_LEN-1:0] addr,
    output logic                rd_req,
    output logic                wr_req,
    input  logic                rd_ready,
    input  logic                wr_ready,
    output logic [XLEN/8-1:0]   be,
    output logic [XLEN-1:0]     wr_data,
    input  logic [XLEN-1:0]     rd_data,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                err_valid,
    output logic [1:0]          err_code,
    output logic [XLEN-1:0]     err_addr
);
    lsu_state_t          state;
    logic [ADDR_LEN-1:0] addr_q;
    logic [2:0]          funct3_q;
    logic [XLEN-1:0]     wdata_q;
    logic [4:0]          rd_q;
    logic                accept;
    logic                mem_op;
    logic                illegal;
    logic                misalign;
    logic                access;
    logic [1:0]          fault_code;
    logic [XLEN/8-1:0]   be_raw;
    logic [XLEN-1:0]     load_data;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid & ex_ready;
    assign mem_op   = ex_load | ex_store;

    always_comb begin
        illegal  = (ex_load & ex_store)
                 | (ex_load & ((ex_funct3 == 3'b011) | (ex_funct3[2:1] == 2'b11)))
                 | (ex_store & (ex_funct3 > F3_SW));
        misalign = mem_op & (((ex_funct3[1:0] == 2'b01) & ex_addr[0])
                 | ((ex_funct3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00)));
        access   = mem_op & (ex_addr[XLEN-1:ADDR_LEN] != '0);
        if (illegal)       fault_code = ERR_ILLEGAL;
        else if (misalign) fault_code = ERR_MISALIGN;
        else if (access)   fault_code = ERR_ACCESS;
        else               fault_code = ERR_NONE;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            addr_q    <= '0;
            funct3_q  <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            err_addr  <= '0;
        end else begin
            wb_valid  <= 1'b0;
            err_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    addr_q   <= ex_addr[ADDR_LEN-1:0];
                    funct3_q <= ex_funct3;
                    wdata_q  <= ex_wdata;
                    rd_q     <= ex_rd;
                    if (fault_code != ERR_NONE) begin
                        err_valid <= 1'b1;
                        err_code  <= fault_code;
                        err_addr  <= ex_addr;
                    end else if (ex_load) begin
                        state <= RD;
                    end else if (ex_store) begin
                        state <= WR;
                    end
                end
                RD: if (rd_ready) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_q;
                    wb_data  <= load_data;
                    state    <= IDLE;
                end
                WR: if (wr_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3    (funct3_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .rd_data   (rd_data),
        .be        (be_raw),
        .wr_data   (wr_data),
        .load_data (load_data)
    );

    // Requests decode straight from state so reset removes them without waiting for a clock.
    assign rd_req = (state == RD);
    assign wr_req = (state == WR);
    assign addr   = addr_q;
    assign be     = (state == IDLE) ? '0 : be_raw;
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu against an arithmetic reference model
module tb_lsu;
    logic        clk = 1'b0;
    logic        rstb;
    logic        ex_valid, ex_ready, ex_load, ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic [13:0] addr;
    logic        rd_req, wr_req, rd_ready, wr_ready;
    logic [3:0]  be;
    logic [31:0] wr_data, rd_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [31:0] err_addr;
    int          checks = 0;
    int          errors = 0;

    lsu dut (
        .clk(clk), .rstb(rstb), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_load(ex_load), .ex_store(ex_store), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .addr(addr),
        .rd_req(rd_req), .wr_req(wr_req), .rd_ready(rd_ready), .wr_ready(wr_ready),
        .be(be), .wr_data(wr_data), .rd_data(rd_data), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .err_valid(err_valid),
        .err_code(err_code), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] m_fault(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz = 1 << f3[1:0];
        if (ld && st) return 2'd3;
        if (ld && (f3 == 3 || f3 >= 6)) return 2'd3;
        if (st && f3 > 2) return 2'd3;
        if (!ld && !st) return 2'd0;
        if (a % sz != 0) return 2'd1;
        if (a >= 32'h4000) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = 1 << f3[1:0];
        int m  = ((1 << sz) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        if (f3[1:0] == 0) return (w & 32'hFF) * 32'h01010101;
        if (f3[1:0] == 1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        longint sz = longint'(1) << f3[1:0];
        longint s  = longint'(d >> (8 * (a % 4)));
        if (sz == 4) return d;
        s = s % (longint'(1) << (8 * sz));
        if (!f3[2] && s >= (longint'(1) << (8 * sz - 1))) s = s - (longint'(1) << (8 * sz));
        return s[31:0];
    endfunction

    // Entered and left at posedge+1 with the LSU idle.
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] w, input logic [4:0] rd, input logic [31:0] rdat, input int dly);
        logic [1:0] code;
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL idle_ex_ready got %b exp 1", ex_ready); end
        ex_valid = 1; ex_load = ld; ex_store = st; ex_funct3 = f3; ex_addr = a; ex_wdata = w; ex_rd = rd;
        rd_data = rdat;
        @(posedge clk); #1;
        ex_valid = 0; ex_load = 0; ex_store = 0; ex_addr = $urandom; ex_wdata = $urandom;
        code = m_fault(ld, st, f3, a);
        if (code != 0) begin
            checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL err_valid got %b exp 1", err_valid); end
            checks++; if (err_code !== code) begin errors++; $display("FAIL err_code got %b exp %b", err_code, code); end
            checks++; if (err_addr !== a) begin errors++; $display("FAIL err_addr got %h exp %h", err_addr, a); end
            checks++; if ({rd_req, wr_req, ex_ready} !== 3'b001) begin errors++; $display("FAIL fault_no_req got %b exp 001", {rd_req, wr_req, ex_ready}); end
            @(posedge clk); #1;
            checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL err_pulse_len got %b exp 0", err_valid); end
        end else if (!ld && !st) begin
            checks++; if ({rd_req, wr_req, err_valid, ex_ready, be} !== 8'b00010000) begin
                errors++; $display("FAIL noop got %b exp 00010000", {rd_req, wr_req, err_valid, ex_ready, be}); end
        end else begin
            checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL good_no_err got %b exp 0", err_valid); end
            for (int c = 0; c <= dly; c++) begin
                checks++; if ({rd_req, wr_req} !== {ld, st}) begin errors++; $display("FAIL req cyc %0d got %b exp %b", c, {rd_req, wr_req}, {ld, st}); end
                checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL busy_ex_ready got %b exp 0", ex_ready); end
                checks++; if (addr !== a[13:0]) begin errors++; $display("FAIL addr got %h exp %h", addr, a[13:0]); end
                checks++; if (be !== m_be(f3, a)) begin errors++; $display("FAIL be got %b exp %b", be, m_be(f3, a)); end
                checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL early_wb got %b exp 0", wb_valid); end
                if (st) begin
                    checks++; if (wr_data !== m_wdata(f3, w)) begin errors++; $display("FAIL wr_data got %h exp %h", wr_data, m_wdata(f3, w)); end
                end
                if (c == dly) begin
                    if (ld) rd_ready = 1; else wr_ready = 1;
                end else begin
                    if (ld) wr_ready = 1'($urandom); else rd_ready = 1'($urandom);
                end
                @(posedge clk); #1;
                rd_ready = 0; wr_ready = 0;
            end
            checks++; if ({rd_req, wr_req, ex_ready, be} !== 7'b0010000) begin
                errors++; $display("FAIL done_idle got %b exp 0010000", {rd_req, wr_req, ex_ready, be}); end
            if (ld) begin
                checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL wb_valid got %b exp 1", wb_valid); end
                checks++; if (wb_data !== m_load(f3, a, rdat)) begin errors++; $display("FAIL wb_data got %h exp %h", wb_data, m_load(f3, a, rdat)); end
                checks++; if (wb_rd !== rd) begin errors++; $display("FAIL wb_rd got %0d exp %0d", wb_rd, rd); end
                rd_data = $urandom;
                @(posedge clk); #1;
                checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL wb_pulse_len got %b exp 0", wb_valid); end
                checks++; if (wb_data !== m_load(f3, a, rdat)) begin errors++; $display("FAIL wb_hold got %h exp %h", wb_data, m_load(f3, a, rdat)); end
            end else begin
                checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL store_wb got %b exp 0", wb_valid); end
            end
        end
    endtask

    task automatic test_reset();
        rstb = 0; ex_valid = 0; ex_load = 0; ex_store = 0; ex_funct3 = 0; ex_addr = 0;
        ex_wdata = 0; ex_rd = 0; rd_ready = 0; wr_ready = 0; rd_data = 0;
        repeat (2) @(posedge clk); #1;
        checks++; if ({rd_req, wr_req, be, wb_valid, err_valid, err_code} !== 10'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0", {rd_req, wr_req, be, wb_valid, err_valid, err_code}); end
        checks++; if ({wb_rd, wb_data, err_addr, addr, wr_data} !== 115'b0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {wb_rd, wb_data, err_addr, addr, wr_data}); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got %b exp 1", ex_ready); end
        @(negedge clk); rstb = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        run_op(1, 0, 3'b010, 32'h2004, 0, 5'd7, 32'hDEADBEEF, 1);
        checks++; if (wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_const got %h exp deadbeef", wb_data); end
    endtask

    task automatic test_lb();
        run_op(1, 0, 3'b000, 32'h2003, 0, 5'd3, 32'h80FFFFFF, 0);
        checks++; if (wb_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_const got %h exp ffffff80", wb_data); end
        run_op(1, 0, 3'b100, 32'h2003, 0, 5'd4, 32'h80FFFFFF, 0);
        checks++; if (wb_data !== 32'h00000080) begin errors++; $display("FAIL lbu_const got %h exp 00000080", wb_data); end
    endtask

    task automatic test_sh();
        run_op(0, 1, 3'b001, 32'h2002, 32'h1234ABCD, 0, 0, 0);
        checks++; if (wr_data !== 32'hABCDABCD) begin errors++; $display("FAIL sh_const got %h exp abcdabcd", wr_data); end
    endtask

    task automatic test_faults();
        run_op(1, 0, 3'b010, 32'h2001, 0, 1, 0, 0);
        run_op(1, 0, 3'b001, 32'h00010000, 0, 1, 0, 0);
        checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL access_const got %b exp 10", err_code); end
        run_op(1, 0, 3'b011, 32'h2000, 0, 1, 0, 0);
        run_op(0, 1, 3'b011, 32'h2000, 0, 1, 0, 0);
        run_op(1, 1, 3'b000, 32'h2000, 0, 1, 0, 0);
        run_op(0, 0, 3'b010, 32'h2001, 0, 1, 0, 0);
    endtask

    task automatic test_hold();
        run_op(1, 0, 3'b101, 32'h0FFE, 0, 5'd31, $urandom, 5);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            int k = $urandom % 8;
            logic [31:0] a = $urandom;
            if ($urandom % 5 != 0) a = a & 32'h3FFF;
            if ($urandom % 2 != 0) a = a & ~32'h3;
            run_op(k < 3 || k == 7, (k >= 3 && k < 6) || k == 7, 3'($urandom), a, $urandom,
                   5'($urandom), $urandom, $urandom % 4);
        end
    endtask

    task automatic test_reset_in_rd();
        ex_valid = 1; ex_load = 1; ex_funct3 = 3'b010; ex_addr = 32'h2000; ex_rd = 5'd9;
        @(posedge clk); #1;
        ex_valid = 0; ex_load = 0;
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL rst_rd_req_pre got %b exp 1", rd_req); end
        #2 rstb = 0;
        #1;
        checks++; if ({rd_req, be, ex_ready} !== 6'b000001) begin errors++; $display("FAIL rst_async got %b exp 000001", {rd_req, be, ex_ready}); end
        rd_ready = 1;
        @(negedge clk); rstb = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if ({wb_valid, err_valid, rd_req} !== 3'b000) begin
                errors++; $display("FAIL rst_drop cyc %0d got %b exp 000", i, {wb_valid, err_valid, rd_req}); end
        end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL rst_wb_data got %h exp 0", wb_data); end
        rd_ready = 0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_faults();
        test_hold();
        test_back_to_back();
        test_reset_in_rd();
        test_lw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
